// File: rtl/inst_queue_if.sv
// inst_queue_if: IF->queue->ID handshake, flush and occupancy bundle
interface inst_queue_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
);
  logic                     fs_to_iq_valid;
  logic [WIDTH-1:0]         fs_to_iq_bus;
  logic                     iq_allowin;
  logic                     iq_to_ds_valid;
  logic [WIDTH-1:0]         iq_to_ds_bus;
  logic                     ds_allowin;
  logic                     flush;
  logic [$clog2(DEPTH):0]   iq_count;
  modport master (
    output fs_to_iq_valid, fs_to_iq_bus, ds_allowin, flush,
    input  iq_allowin, iq_to_ds_valid, iq_to_ds_bus, iq_count
  );
  modport slave (
    input  fs_to_iq_valid, fs_to_iq_bus, ds_allowin, flush,
    output iq_allowin, iq_to_ds_valid, iq_to_ds_bus, iq_count
  );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode FIFO with flush discard and post-exception drop
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input logic         clk_i,
  input logic         reset_i,
  inst_queue_if.slave iq
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, wptr_q;
  logic [AW:0]      count_q, count_d;
  logic             hold_q;
  logic             push, pop;
  assign iq.iq_allowin     = count_q != (AW+1)'(DEPTH);
  assign iq.iq_to_ds_valid = (count_q != '0) & ~iq.flush;
  assign iq.iq_to_ds_bus   = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign iq.iq_count       = count_q;
  // accepted-but-dropped entries after an exception still consume the IF handshake
  assign push    = iq.fs_to_iq_valid & iq.iq_allowin & ~iq.flush & ~hold_q;
  assign pop     = iq.iq_to_ds_valid & iq.ds_allowin;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      hold_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (iq.flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= iq.fs_to_iq_bus;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      hold_q  <= hold_q | (push & iq.fs_to_iq_bus[WIDTH-1]);
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized and directed checks of inst_queue against a queue-based model
module tb_inst_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  inst_queue_if #(.DEPTH(4), .WIDTH(66)) f();
  inst_queue #(.DEPTH(4), .WIDTH(66)) dut (.clk_i(clk), .reset_i(reset), .iq(f));
  int passed = 0, total = 0, peak;
  logic [65:0] mq[$], src[$];
  logic [31:0] got[$], sent[$];
  bit mhold;
  logic e_allow, e_valid;
  logic [65:0] e_bus;
  logic [2:0] e_cnt;

  function automatic logic [65:0] ent(bit e, logic [31:0] pc, logic [31:0] inst);
    return {e, 1'b0, pc, inst};
  endfunction

  task automatic set_in(bit v, logic [65:0] b, bit d, bit fl, bit r);
    f.fs_to_iq_valid = v; f.fs_to_iq_bus = b; f.ds_allowin = d; f.flush = fl; reset = r;
    e_allow = mq.size() != 4;
    e_valid = mq.size() != 0 && !fl;
    e_bus   = mq.size() != 0 ? mq[0] : '0;
    e_cnt   = 3'(mq.size());
    #1;
  endtask

  task automatic tick();
    bit pp, po;
    if (reset || f.flush) begin
      mq.delete(); mhold = 0;
    end else begin
      po = e_valid && f.ds_allowin;
      pp = f.fs_to_iq_valid && e_allow && !mhold;
      if (po) void'(mq.pop_front());
      if (pp) begin
        mq.push_back(f.fs_to_iq_bus);
        if (f.fs_to_iq_bus[65]) mhold = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_src(bit d);
    if (src.size() != 0) set_in(1, src[0], d, 0, 0);
    else set_in(0, '0, d, 0, 0);
  endtask

  task automatic adv();
    if (f.fs_to_iq_valid && e_allow) begin
      sent.push_back(f.fs_to_iq_bus[63:32]);
      if (src.size() != 0) void'(src.pop_front());
    end
    if (f.iq_to_ds_valid && f.ds_allowin) got.push_back(f.iq_to_ds_bus[63:32]);
    if (int'(f.iq_count) > peak) peak = int'(f.iq_count);
    tick();
  endtask

  task automatic test_reset();
    set_in(0, '0, 0, 0, 1); tick(); tick();
    set_in(0, '0, 0, 0, 0);
    total++;
    if ({f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus} !== {1'b0, 1'b1, 3'd0, 66'd0})
      $display("FAIL reset: got v=%b a=%b n=%0d bus=%h want v=0 a=1 n=0 bus=0", f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus);
    else passed++;
    tick();
  endtask

  task automatic test_passthrough();
    got.delete(); src.delete(); peak = 0;
    for (int i = 0; i < 4; i++) src.push_back(ent(0, 32'h1c000000 + 4*i, 32'hA0 + i));
    for (int c = 0; c < 20 && !(src.size() == 0 && mq.size() == 0); c++) begin
      drive_src(1);
      total++;
      if ({f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus} !== {e_valid, e_allow, e_cnt, e_bus})
        $display("FAIL pass: got v=%b a=%b n=%0d bus=%h want v=%b a=%b n=%0d bus=%h", f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus, e_valid, e_allow, e_cnt, e_bus);
      else passed++;
      adv();
    end
    total++;
    if (got.size() != 4 || got[0] !== 32'h1c000000 || got[3] !== 32'h1c00000c)
      $display("FAIL pass_order: got n=%0d want 4 in order 1c000000..1c00000c", got.size());
    else passed++;
    total++;
    if (peak != 1) $display("FAIL pass_peak: got %0d want 1", peak); else passed++;
  endtask

  task automatic test_full();
    got.delete(); src.delete();
    for (int i = 0; i < 5; i++) src.push_back(ent(0, 32'h1c000000 + 4*i, 32'hB0 + i));
    for (int c = 0; c < 6; c++) begin
      drive_src(0);
      total++;
      if ({f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus} !== {e_valid, e_allow, e_cnt, e_bus})
        $display("FAIL full: got v=%b a=%b n=%0d bus=%h want v=%b a=%b n=%0d bus=%h", f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus, e_valid, e_allow, e_cnt, e_bus);
      else passed++;
      adv();
    end
    total++;
    if (f.iq_count !== 3'd4 || f.iq_allowin !== 1'b0)
      $display("FAIL full_state: got n=%0d a=%b want n=4 a=0", f.iq_count, f.iq_allowin);
    else passed++;
    for (int c = 0; c < 20 && !(src.size() == 0 && mq.size() == 0); c++) begin
      drive_src(1);
      total++;
      if ({f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus} !== {e_valid, e_allow, e_cnt, e_bus})
        $display("FAIL drain: got v=%b a=%b n=%0d bus=%h want v=%b a=%b n=%0d bus=%h", f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus, e_valid, e_allow, e_cnt, e_bus);
      else passed++;
      adv();
    end
    total++;
    if (got.size() != 5) $display("FAIL full_count: got %0d want 5", got.size());
    else begin
      passed++;
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got[i] !== 32'h1c000000 + 4*i) $display("FAIL full_pc%0d: got %h want %h", i, got[i], 32'h1c000000 + 4*i);
        else passed++;
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin set_in(1, ent(0, 32'h1c001000 + 4*i, i), 0, 0, 0); tick(); end
    set_in(1, ent(0, 32'h1c00beef, 32'h1), 1, 1, 0);
    total++;
    if ({f.iq_to_ds_valid, f.iq_count} !== {1'b0, 3'd3})
      $display("FAIL flush_cyc: got v=%b n=%0d want v=0 n=3", f.iq_to_ds_valid, f.iq_count);
    else passed++;
    tick();
    set_in(0, '0, 1, 0, 0);
    total++;
    if ({f.iq_to_ds_valid, f.iq_allowin, f.iq_count} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL flush_after: got v=%b a=%b n=%0d want v=0 a=1 n=0", f.iq_to_ds_valid, f.iq_allowin, f.iq_count);
    else passed++;
    tick();
    set_in(1, ent(0, 32'h1c008000, 32'hC0), 0, 0, 0); tick();
    set_in(0, '0, 0, 0, 0);
    total++;
    if ({f.iq_to_ds_valid, f.iq_count, f.iq_to_ds_bus} !== {e_valid, e_cnt, e_bus} || f.iq_to_ds_bus[63:32] !== 32'h1c008000)
      $display("FAIL flush_head: got v=%b n=%0d pc=%h want v=1 n=1 pc=1c008000", f.iq_to_ds_valid, f.iq_count, f.iq_to_ds_bus[63:32]);
    else passed++;
    tick();
    set_in(0, '0, 1, 0, 0); tick();
  endtask

  task automatic test_excp();
    got.delete(); src.delete(); peak = 0;
    src.push_back(ent(1, 32'h1c000002, 32'hD0));
    src.push_back(ent(0, 32'h1c000006, 32'hD1));
    src.push_back(ent(0, 32'h1c00000a, 32'hD2));
    for (int c = 0; c < 8; c++) begin
      drive_src(1);
      total++;
      if ({f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus} !== {e_valid, e_allow, e_cnt, e_bus})
        $display("FAIL excp: got v=%b a=%b n=%0d bus=%h want v=%b a=%b n=%0d bus=%h", f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus, e_valid, e_allow, e_cnt, e_bus);
      else passed++;
      adv();
    end
    total++;
    if (got.size() != 1 || got[0] !== 32'h1c000002 || peak != 1)
      $display("FAIL excp_only: got n=%0d peak=%0d want n=1 pc=1c000002 peak=1", got.size(), peak);
    else passed++;
    set_in(0, '0, 1, 1, 0); tick();
    src.push_back(ent(0, 32'h1c008000, 32'hD3));
    for (int c = 0; c < 10 && !(src.size() == 0 && mq.size() == 0); c++) begin drive_src(1); adv(); end
    total++;
    if (got.size() != 2 || got[got.size()-1] !== 32'h1c008000)
      $display("FAIL excp_after_flush: got n=%0d want 2 ending 1c008000", got.size());
    else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] pc = 32'h1c010000;
    got.delete(); src.delete(); sent.delete(); peak = 0;
    for (int c = 0; c < 40; c++) begin
      if (src.size() < 2) begin src.push_back({1'b0, 1'($urandom), pc, $urandom}); pc += 4; end
      set_in($urandom_range(0, 3) != 0, src[0], 1'($urandom), 0, 0);
      total++;
      if ({f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus} !== {e_valid, e_allow, e_cnt, e_bus})
        $display("FAIL wrap: got v=%b a=%b n=%0d bus=%h want v=%b a=%b n=%0d bus=%h", f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus, e_valid, e_allow, e_cnt, e_bus);
      else passed++;
      adv();
    end
    for (int c = 0; c < 20 && mq.size() != 0; c++) begin set_in(0, '0, 1, 0, 0); adv(); end
    total++;
    if (got != sent || peak > 4) $display("FAIL wrap_sb: got %0d delivered want %0d, peak %0d", got.size(), sent.size(), peak);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin set_in(1, ent(0, 32'h1c020000 + 4*i, i), 0, 0, 0); tick(); end
    set_in(1, ent(1, 32'h1c02000c, 32'hE0), 0, 0, 0); tick();
    set_in(1, ent(0, 32'h1c020010, 32'hE1), 0, 0, 0);
    total++;
    if ({f.iq_allowin, f.iq_count} !== {1'b0, 3'd4}) $display("FAIL rst_full: got a=%b n=%0d want a=0 n=4", f.iq_allowin, f.iq_count);
    else passed++;
    tick();
    set_in(1, ent(0, 32'h1c020014, 32'hE2), 1, 1, 1); tick();
    set_in(0, '0, 0, 0, 0);
    total++;
    if ({f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus} !== {1'b0, 1'b1, 3'd0, 66'd0})
      $display("FAIL rst_mid: got v=%b a=%b n=%0d bus=%h want v=0 a=1 n=0 bus=0", f.iq_to_ds_valid, f.iq_allowin, f.iq_count, f.iq_to_ds_bus);
    else passed++;
    tick();
    set_in(1, ent(0, 32'h1c030000, 32'hF0), 0, 0, 0); tick();
    set_in(0, '0, 0, 0, 0);
    total++;
    if ({f.iq_to_ds_valid, f.iq_count, f.iq_to_ds_bus} !== {e_valid, e_cnt, e_bus} || e_cnt !== 3'd1)
      $display("FAIL rst_hold_clr: got v=%b n=%0d bus=%h want v=%b n=%0d bus=%h", f.iq_to_ds_valid, f.iq_count, f.iq_to_ds_bus, e_valid, e_cnt, e_bus);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_full();
    test_flush();
    test_excp();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
